// File: rtl/sw_pkg.sv
// Shared constants for the switch input-conditioning slice.
// Widths and debounce lengths for hardware and simulation builds.
package sw_pkg;

  localparam int SW_WIDTH            = 8;
  localparam int DEBOUNCE_CYCLES_HW  = 50000;
  localparam int DEBOUNCE_CYCLES_SIM = 4;
  localparam int CNT_W               = 16;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter,
// stable level and registered rise/fall pulses.
module debounce_bit #(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic             diff;
  logic             done;

  always_comb begin
    diff = sync2 != stable;
    done = diff && (cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      unique case (1'b1)
        !diff: cnt <= '0;
        done: begin
          // pulses land with the new stable value
          stable <= sync2;
          cnt    <= '0;
          rise   <= sync2;
          fall   <= ~sync2;
        end
        default: cnt <= cnt + CNT_W'(1);
      endcase
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debounced switch vector feeding the priority encoder,
// plus per-bit edge pulses and a combined change strobe.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int CNT_W           = sw_pkg::CNT_W,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_HW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_raw[i]),
      .stable(sw_stable[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  assign sw_changed = |(sw_rise | sw_fall);

endmodule
